// File: rtl/mem_port_arbiter.sv
// Shares the single physical-memory port between the I-cache and the D-cache.
// Each grant moves one full cache line. D has priority, but a streak limit guarantees I progress.
module mem_port_arbiter #(
   parameter int unsigned LINE_W       = 256,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
   localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

   typedef enum logic [1:0] {StIdle, StServeI, StServeD, StDone} state_e;

   state_e              state_q, state_d;
   logic [StreakW-1:0]  d_streak_q, d_streak_d;
   logic                pmem_read_q, pmem_read_d;
   logic                pmem_write_q, pmem_write_d;
   logic [ADDR_W-1:0]   pmem_addr_q, pmem_addr_d;
   logic [LINE_W-1:0]   pmem_wdata_q, pmem_wdata_d;
   logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
   logic                i_resp_q, i_resp_d;
   logic                d_resp_q, d_resp_d;
   logic                d_req;

   assign d_req = d_read | d_write;

   always_comb begin
      state_d      = state_q;
      d_streak_d   = d_streak_q;
      pmem_read_d  = pmem_read_q;
      pmem_write_d = pmem_write_q;
      pmem_addr_d  = pmem_addr_q;
      pmem_wdata_d = pmem_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_resp_d     = 1'b0;
      d_resp_d     = 1'b0;
      case (state_q)
         StIdle: begin
            // I wins when alone, or when D has used up its streak while I waited.
            if (i_read && (!d_req || d_streak_q == StreakMax)) begin
               state_d     = StServeI;
               pmem_read_d = 1'b1;
               pmem_addr_d = i_addr;
               d_streak_d  = '0;
            end else if (d_req) begin
               state_d      = StServeD;
               pmem_write_d = d_write;
               pmem_read_d  = ~d_write;
               pmem_addr_d  = d_addr;
               pmem_wdata_d = d_wdata;
               if (!i_read) begin
                  d_streak_d = '0;
               end else if (d_streak_q != StreakMax) begin
                  d_streak_d = d_streak_q + StreakW'(1);
               end
            end
         end
         StServeI: begin
            if (pmem_resp) begin
               state_d     = StDone;
               pmem_read_d = 1'b0;
               i_rdata_d   = pmem_rdata;
               i_resp_d    = 1'b1;
            end
         end
         StServeD: begin
            if (pmem_resp) begin
               state_d      = StDone;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               if (!pmem_write_q) begin
                  d_rdata_d = pmem_rdata;
               end
               d_resp_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         d_streak_q   <= '0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         pmem_addr_q  <= '0;
         pmem_wdata_q <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         d_streak_q   <= d_streak_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
         pmem_addr_q  <= pmem_addr_d;
         pmem_wdata_q <= pmem_wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_resp_q     <= i_resp_d;
         d_resp_q     <= d_resp_d;
      end
   end

   assign pmem_read  = pmem_read_q;
   assign pmem_write = pmem_write_q;
   assign pmem_addr  = pmem_addr_q;
   assign pmem_wdata = pmem_wdata_q;
   assign i_rdata    = i_rdata_q;
   assign d_rdata    = d_rdata_q;
   assign i_resp     = i_resp_q;
   assign d_resp     = d_resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random cache requesters and a variable-latency memory.
// A transaction-level model predicts grants, strobes, responses and returned lines.
module tb_mem_port_arbiter;

   localparam int unsigned LineW = 256;
   localparam int unsigned AddrW = 32;
   localparam int unsigned MaxDs = 4;

   logic             clk;
   logic             rst;
   logic             i_read;
   logic [AddrW-1:0] i_addr;
   logic [LineW-1:0] i_rdata;
   logic             i_resp;
   logic             d_read;
   logic             d_write;
   logic [AddrW-1:0] d_addr;
   logic [LineW-1:0] d_wdata;
   logic [LineW-1:0] d_rdata;
   logic             d_resp;
   logic             pmem_read;
   logic             pmem_write;
   logic [AddrW-1:0] pmem_addr;
   logic [LineW-1:0] pmem_wdata;
   logic [LineW-1:0] pmem_rdata;
   logic             pmem_resp;

   mem_port_arbiter #(
      .LINE_W       (LineW),
      .ADDR_W       (AddrW),
      .MAX_D_STREAK (MaxDs)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_read     (i_read),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .pmem_rdata (pmem_rdata),
      .pmem_resp  (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Transaction-level model of the port.
   bit               m_busy, m_wait, m_is_d, m_write;
   int               m_streak;
   logic [AddrW-1:0] m_addr;
   logic [LineW-1:0] m_wdata;
   logic [LineW-1:0] exp_i_rdata, exp_d_rdata;
   bit               exp_i_resp, exp_d_resp;
   logic [10:0]      grant_log;
   int               grant_cnt;

   // Memory and requester behaviour knobs.
   bit mem_active;
   int mem_cnt;
   int p_i, p_d, p_spur;

   task automatic check(input string tag, input logic [LineW-1:0] got,
                        input logic [LineW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [LineW-1:0] rand_line();
      logic [LineW-1:0] r;
      for (int k = 0; k < LineW / 32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic model_reset();
      m_busy      = 1'b0;
      m_wait      = 1'b0;
      m_streak    = 0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      grant_log   = '0;
      grant_cnt   = 0;
      mem_active  = 1'b0;
      mem_cnt     = 0;
   endtask

   task automatic record_grant(input bit is_i);
      if (grant_cnt < 11) grant_log = {grant_log[9:0], is_i};
      grant_cnt++;
   endtask

   // One clock: predict the edge from the inputs it sampled, check, then drive the next cycle.
   task automatic step();
      bit d_req, strobe;
      int op;
      @(posedge clk);
      #1;
      exp_i_resp = 1'b0;
      exp_d_resp = 1'b0;
      d_req = d_read || d_write;
      if (m_busy) begin
         if (pmem_resp) begin
            m_busy = 1'b0;
            m_wait = 1'b1;
            if (m_is_d) begin
               exp_d_resp = 1'b1;
               if (!m_write) exp_d_rdata = pmem_rdata;
            end else begin
               exp_i_resp  = 1'b1;
               exp_i_rdata = pmem_rdata;
            end
         end
      end else if (m_wait) begin
         m_wait = 1'b0;
      end else if (i_read && (!d_req || m_streak >= MaxDs)) begin
         m_busy = 1'b1; m_is_d = 1'b0; m_write = 1'b0; m_addr = i_addr; m_streak = 0;
         record_grant(1'b1);
      end else if (d_req) begin
         m_busy = 1'b1; m_is_d = 1'b1; m_write = d_write; m_addr = d_addr; m_wdata = d_wdata;
         m_streak = i_read ? ((m_streak + 1 > MaxDs) ? MaxDs : m_streak + 1) : 0;
         record_grant(1'b0);
      end

      check("pmem_read", pmem_read, m_busy && !(m_is_d && m_write));
      check("pmem_write", pmem_write, m_busy && m_is_d && m_write);
      if (m_busy) check("pmem_addr", pmem_addr, m_addr);
      if (m_busy && m_write) check("pmem_wdata", pmem_wdata, m_wdata);
      check("i_resp", i_resp, exp_i_resp);
      check("d_resp", d_resp, exp_d_resp);
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);

      // Memory: random latency 1..4 cycles from first sight of a strobe, plus spurious pulses.
      strobe     = pmem_read || pmem_write;
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      if (!mem_active && strobe) begin
         mem_active = 1'b1;
         mem_cnt    = $urandom_range(4, 1);
      end
      if (mem_active) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            pmem_resp  = 1'b1;
            mem_active = 1'b0;
         end
      end else if (!m_busy && ($urandom() % 100) < p_spur) begin
         pmem_resp = 1'b1;
      end

      // Requesters hold until their resp, drop in that cycle, and may re-request after.
      if (i_resp) i_read = 1'b0;
      else if (!i_read && ($urandom() % 100) < p_i) i_read = 1'b1;
      if (d_resp) begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end else if (!d_req && ($urandom() % 100) < p_d) begin
         op      = $urandom_range(2, 0);
         d_read  = (op != 1);
         d_write = (op != 0);
      end
      // Addresses and write data wander freely; only the grant-time values may matter.
      if ($urandom() % 2 == 0) i_addr = $urandom();
      if ($urandom() % 2 == 0) d_addr = $urandom();
      if ($urandom() % 2 == 0) d_wdata = rand_line();
   endtask

   initial begin
      rst        = 1'b1;
      i_read     = 1'b0;
      i_addr     = '0;
      d_read     = 1'b0;
      d_write    = 1'b0;
      d_addr     = '0;
      d_wdata    = '0;
      pmem_rdata = '0;
      pmem_resp  = 1'b0;
      p_i        = 40;
      p_d        = 40;
      p_spur     = 10;
      model_reset();

      #2 rst = 1'b0;
      #1;
      check("rst_pmem_read", pmem_read, 1'b0);
      check("rst_pmem_write", pmem_write, 1'b0);
      check("rst_pmem_addr", pmem_addr, '0);
      check("rst_pmem_wdata", pmem_wdata, '0);
      check("rst_i_resp", i_resp, 1'b0);
      check("rst_d_resp", d_resp, 1'b0);
      check("rst_i_rdata", i_rdata, '0);
      check("rst_d_rdata", d_rdata, '0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      repeat (1500) step();

      // Steer towards a D write in flight, then pull reset mid-cycle.
      p_d = 90;
      p_i = 10;
      begin
         bit found = 1'b0;
         for (int n = 0; n < 300 && !found; n++) begin
            step();
            found = m_busy && m_is_d && m_write && !pmem_resp;
         end
         check("found_d_write", found, 1'b1);
      end
      #2 rst = 1'b0;
      #1;
      check("abort_pmem_write", pmem_write, 1'b0);
      check("abort_pmem_read", pmem_read, 1'b0);
      check("abort_pmem_addr", pmem_addr, '0);
      check("abort_d_resp", d_resp, 1'b0);
      pmem_resp = 1'b0;
      i_read    = 1'b1;
      d_read    = 1'b0;
      d_write   = 1'b0;
      model_reset();
      @(posedge clk);
      #1 check("abort_no_d_resp", d_resp, 1'b0);
      @(negedge clk) rst = 1'b1;

      // Both sides requesting continuously: I first (alone), then D x MAX_D_STREAK, I, ...
      p_i    = 100;
      p_d    = 100;
      p_spur = 20;
      for (int n = 0; n < 300 && grant_cnt < 11; n++) step();
      check("grant_order", grant_log, 11'b10000100001);

      p_i = 50;
      p_d = 50;
      repeat (1000) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
